wb_arbiter2: RTL and testbench



---
 rtl/wb_arb_pkg.sv | 24 ++
 rtl/wb_arb_watchdog.sv | 45 ++++
 rtl/wb_arbiter2.sv | 146 ++++++++++++++
 tb/tb_wb_arbiter2.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared encodings for the two-master Wishbone arbiter: FSM states and one-hot grant values.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGnt0 = 2'd1,
        StGnt1 = 2'd2
    } state_e;

    localparam logic [1:0] GrantNone = 2'b00;
    localparam logic [1:0] Grant0    = 2'b01;
    localparam logic [1:0] Grant1    = 2'b10;

    function automatic logic [1:0] grant_of(state_e st);
        logic [1:0] g;
        case (st)
            StGnt0:  g = Grant0;
            StGnt1:  g = Grant1;
            default: g = GrantNone;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog: counts strobed cycles without termination and fires a forced error at the limit.
module wb_arb_watchdog #(
    parameter int unsigned timeout_cycles = 255,
    parameter int unsigned cnt_width      = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic active,
    input  logic term,
    input  logic clear,
    output logic fire,
    output logic timeout_o
);

    localparam logic [cnt_width-1:0] limit =
        (timeout_cycles == 0) ? '0 : cnt_width'(timeout_cycles - 1);

    logic [cnt_width-1:0] cnt_q, cnt_d;
    logic                 timeout_q;

    assign fire = (timeout_cycles != 0) && active && !term && (cnt_q == limit);

    always_comb begin
        cnt_d = cnt_q;
        if (!active || term || clear || fire) begin
            cnt_d = '0;
        end else if (cnt_q != {cnt_width{1'b1}}) begin
            // Saturate so a disabled watchdog never wraps.
            cnt_d = cnt_q + cnt_width'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= fire;
        end
    end

    assign timeout_o = timeout_q;

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master to one-slave Wishbone arbiter: round-robin grant, locked for the owner's whole cycle.
module wb_arbiter2
    import wb_arb_pkg::*;
#(
    parameter int unsigned adr_width      = 32,
    parameter int unsigned timeout_cycles = 255,
    parameter int unsigned cnt_width      = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [adr_width-1:0] m0_adr_i,
    input  logic [31:0]          m0_dat_i,
    output logic [31:0]          m0_dat_o,
    input  logic [3:0]           m0_sel_i,
    input  logic                 m0_we_i,
    input  logic                 m0_cyc_i,
    input  logic                 m0_stb_i,
    output logic                 m0_ack_o,
    output logic                 m0_err_o,
    output logic                 m0_rty_o,
    input  logic [adr_width-1:0] m1_adr_i,
    input  logic [31:0]          m1_dat_i,
    output logic [31:0]          m1_dat_o,
    input  logic [3:0]           m1_sel_i,
    input  logic                 m1_we_i,
    input  logic                 m1_cyc_i,
    input  logic                 m1_stb_i,
    output logic                 m1_ack_o,
    output logic                 m1_err_o,
    output logic                 m1_rty_o,
    output logic [adr_width-1:0] s_adr_o,
    output logic [31:0]          s_dat_o,
    input  logic [31:0]          s_dat_i,
    output logic [3:0]           s_sel_o,
    output logic                 s_we_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    input  logic                 s_ack_i,
    input  logic                 s_err_i,
    input  logic                 s_rty_i,
    output logic [1:0]           grant_o,
    output logic                 timeout_o
);

    state_e     state_q, state_d;
    logic       last_q, last_d;
    logic [1:0] grant_q, grant_d;
    logic       stb_raw;
    logic       term;
    logic       wd_fire;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            grant_q <= GrantNone;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

    // The owner keeps the bus until its cyc drops; a waiting master then takes over directly.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? StGnt0 : StGnt1;
                end else if (m0_cyc_i) begin
                    state_d = StGnt0;
                end else if (m1_cyc_i) begin
                    state_d = StGnt1;
                end
            end
            StGnt0: begin
                if (!m0_cyc_i) begin
                    last_d  = 1'b0;
                    state_d = m1_cyc_i ? StGnt1 : StIdle;
                end
            end
            StGnt1: begin
                if (!m1_cyc_i) begin
                    last_d  = 1'b1;
                    state_d = m0_cyc_i ? StGnt0 : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        grant_d = grant_of(state_d);
    end

    always_comb begin
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        stb_raw = 1'b0;
        unique case (state_q)
            StGnt0: begin
                s_we_o  = m0_we_i;
                s_cyc_o = m0_cyc_i;
                stb_raw = m0_stb_i;
            end
            StGnt1: begin
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                s_sel_o = m1_sel_i;
                s_we_o  = m1_we_i;
                s_cyc_o = m1_cyc_i;
                stb_raw = m1_stb_i;
            end
            default: ;
        endcase
    end

    assign term    = s_ack_i | s_err_i | s_rty_i;
    assign s_stb_o = stb_raw & ~wd_fire;

    wb_arb_watchdog #(
        .timeout_cycles (timeout_cycles),
        .cnt_width      (cnt_width)
    ) u_watchdog (
        .clk       (clk),
        .reset_n   (reset_n),
        .active    (s_cyc_o & stb_raw),
        .term      (term),
        .clear     (state_d != state_q),
        .fire      (wd_fire),
        .timeout_o (timeout_o)
    );

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = s_ack_i & grant_q[0];
    assign m0_rty_o = s_rty_i & grant_q[0];
    assign m0_err_o = (s_err_i | wd_fire) & grant_q[0];
    assign m1_ack_o = s_ack_i & grant_q[1];
    assign m1_rty_o = s_rty_i & grant_q[1];
    assign m1_err_o = (s_err_i | wd_fire) & grant_q[1];
    assign grant_o  = grant_q;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: vector table, directed corner sequences and a randomized model comparison.
module tb_wb_arbiter2;

    localparam int WdT = 8;

    logic        clk, reset_n;
    logic [31:0] m0_adr, m1_adr, m0_dat, m1_dat, s_dat_i;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_we, m1_we, m0_cyc, m1_cyc, m0_stb, m1_stb;
    logic        s_ack, s_err, s_rty;

    logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
    logic        s_we_o, s_cyc_o, s_stb_o, timeout_o;
    logic [1:0]  grant_o;

    logic [31:0] z_m0_dat_o, z_m1_dat_o, z_s_adr_o, z_s_dat_o;
    logic [3:0]  z_s_sel_o;
    logic        z_m0_ack_o, z_m0_err_o, z_m0_rty_o, z_m1_ack_o, z_m1_err_o, z_m1_rty_o;
    logic        z_s_we_o, z_s_cyc_o, z_s_stb_o, z_timeout_o;
    logic [1:0]  z_grant_o;

    int checks = 0;
    int errors = 0;

    // Reference model state: owner is -1 when idle, else the master index.
    int m_owner;
    bit m_last;
    int m_stall;
    bit m_tmo;

    wb_arbiter2 #(.adr_width(32), .timeout_cycles(WdT), .cnt_width(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_o), .m0_sel_i(m0_sel),
        .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_o), .m1_sel_i(m1_sel),
        .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    wb_arbiter2 #(.adr_width(32), .timeout_cycles(0), .cnt_width(8)) dut_nowd (
        .clk(clk), .reset_n(reset_n),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(z_m0_dat_o), .m0_sel_i(m0_sel),
        .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb),
        .m0_ack_o(z_m0_ack_o), .m0_err_o(z_m0_err_o), .m0_rty_o(z_m0_rty_o),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(z_m1_dat_o), .m1_sel_i(m1_sel),
        .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb),
        .m1_ack_o(z_m1_ack_o), .m1_err_o(z_m1_err_o), .m1_rty_o(z_m1_rty_o),
        .s_adr_o(z_s_adr_o), .s_dat_o(z_s_dat_o), .s_dat_i(s_dat_i), .s_sel_o(z_s_sel_o),
        .s_we_o(z_s_we_o), .s_cyc_o(z_s_cyc_o), .s_stb_o(z_s_stb_o),
        .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .grant_o(z_grant_o), .timeout_o(z_timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         m0c;
        bit         m1c;
        bit         ack;
        logic [1:0] grant;
        bit         scyc;
        bit         a0;
        bit         a1;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'hf; m0_adr = 32'h0; m0_dat = 32'h0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 4'hf; m1_adr = 32'h0; m1_dat = 32'h0;
        s_ack = 0; s_err = 0; s_rty = 0; s_dat_i = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_owner = -1; m_last = 1'b1; m_stall = 0; m_tmo = 1'b0;
    endtask

    function automatic logic [11:0] dut_vec();
        return {grant_o, s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m0_err_o, m0_rty_o,
                m1_ack_o, m1_err_o, m1_rty_o, timeout_o};
    endfunction

    task automatic model_expect(output logic [11:0] e, output logic fire, output logic [31:0] ea);
        logic c, s, w, t;
        c = 0; s = 0; w = 0;
        if (m_owner == 0) begin c = m0_cyc; s = m0_stb; w = m0_we; end
        if (m_owner == 1) begin c = m1_cyc; s = m1_stb; w = m1_we; end
        t    = s_ack | s_err | s_rty;
        fire = (WdT != 0) && c && s && !t && (m_stall == WdT - 1);
        ea   = (m_owner == 1) ? m1_adr : m0_adr;
        e = {(m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10), c, s & !fire, w,
             s_ack && (m_owner == 0), (s_err || fire) && (m_owner == 0),
             s_rty && (m_owner == 0), s_ack && (m_owner == 1),
             (s_err || fire) && (m_owner == 1), s_rty && (m_owner == 1), m_tmo};
    endtask

    task automatic model_step(input logic fire);
        int nxt;
        logic own_c, own_s, oth_c;
        own_c = (m_owner == 0) ? m0_cyc : (m_owner == 1) ? m1_cyc : 1'b0;
        own_s = (m_owner == 0) ? m0_stb : (m_owner == 1) ? m1_stb : 1'b0;
        oth_c = (m_owner == 0) ? m1_cyc : m0_cyc;
        if (m_owner < 0) begin
            if (m0_cyc && m1_cyc) nxt = m_last ? 0 : 1;
            else if (m0_cyc)      nxt = 0;
            else if (m1_cyc)      nxt = 1;
            else                  nxt = -1;
        end else if (own_c) begin
            nxt = m_owner;
        end else begin
            m_last = (m_owner == 1);
            nxt    = oth_c ? 1 - m_owner : -1;
        end
        if (!(own_c && own_s) || s_ack || s_err || s_rty || fire || nxt != m_owner) m_stall = 0;
        else m_stall++;
        m_tmo   = fire;
        m_owner = nxt;
    endtask

    initial begin
        logic [11:0] e;
        logic        f;
        logic [31:0] ea;

        tbl[0]  = '{1, 1, 0, 2'b00, 0, 0, 0};
        tbl[1]  = '{1, 1, 1, 2'b01, 1, 1, 0};
        tbl[2]  = '{0, 1, 0, 2'b01, 0, 0, 0};
        tbl[3]  = '{1, 1, 1, 2'b10, 1, 0, 1};
        tbl[4]  = '{1, 1, 1, 2'b10, 1, 0, 1};
        tbl[5]  = '{1, 1, 1, 2'b10, 1, 0, 1};
        tbl[6]  = '{1, 1, 1, 2'b10, 1, 0, 1};
        tbl[7]  = '{1, 0, 0, 2'b10, 0, 0, 0};
        tbl[8]  = '{1, 0, 0, 2'b01, 1, 0, 0};
        tbl[9]  = '{0, 0, 0, 2'b01, 0, 0, 0};
        tbl[10] = '{0, 0, 0, 2'b00, 0, 0, 0};
        tbl[11] = '{1, 1, 0, 2'b00, 0, 0, 0};
        tbl[12] = '{1, 1, 1, 2'b10, 1, 0, 1};
        tbl[13] = '{1, 0, 0, 2'b10, 0, 0, 0};
        tbl[14] = '{1, 0, 1, 2'b01, 1, 1, 0};
        tbl[15] = '{0, 0, 0, 2'b01, 0, 0, 0};
        tbl[16] = '{0, 0, 1, 2'b00, 0, 0, 0};

        reset_n = 1'b1;
        idle_inputs();
        do_reset();

        // Asynchronous reset in the middle of an m0 transfer.
        m0_cyc = 1; m0_stb = 1;
        step();
        s_ack = 1;
        #1 chk("pre_reset_ack", {grant_o, m0_ack_o}, {2'b01, 1'b1});
        #1 reset_n = 1'b0;
        #1 chk("async_reset", {s_cyc_o, s_stb_o, m0_ack_o, grant_o, timeout_o}, 5'b0);
        step();
        reset_n = 1'b1;
        m0_cyc = 0; m0_stb = 0; s_ack = 0; m1_cyc = 1; m1_stb = 1;
        #1 chk("post_reset_idle", grant_o, 2'b00);
        step();
        #1 chk("post_reset_m1", {grant_o, s_cyc_o}, {2'b10, 1'b1});

        // Single master read.
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h4000_0010; m1_adr = 32'h1234_5678;
        #1 chk("read_c0", {grant_o, m0_ack_o, m1_ack_o}, 4'b0);
        step();
        #1 chk("read_c1", {s_adr_o, s_stb_o, s_we_o, m0_ack_o, m1_ack_o},
               {32'h4000_0010, 4'b1000});
        step();
        s_ack = 1; s_dat_i = 32'hDEAD_BEEF;
        #1 chk("read_c2", {m0_dat_o, m0_ack_o, m1_ack_o}, {32'hDEAD_BEEF, 2'b10});
        step();
        m0_cyc = 0; m0_stb = 0; s_ack = 0;
        #1 chk("read_c3", {m0_ack_o, m1_ack_o}, 2'b00);

        // Tie, handover and lock sequence from a fresh reset.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            m0_cyc = tbl[i].m0c; m0_stb = tbl[i].m0c;
            m1_cyc = tbl[i].m1c; m1_stb = tbl[i].m1c;
            s_ack  = tbl[i].ack;
            #1 chk($sformatf("table_row%0d", i), {grant_o, s_cyc_o, m0_ack_o, m1_ack_o},
                   {tbl[i].grant, tbl[i].scyc, tbl[i].a0, tbl[i].a1});
            step();
        end

        // Watchdog fires in the eighth stalled strobe cycle; timeout_o follows one cycle later.
        do_reset();
        m0_cyc = 1; m0_stb = 1;
        step();
        for (int k = 0; k < WdT; k++) begin
            #1 chk($sformatf("wd_stall%0d", k), {m0_err_o, s_stb_o, timeout_o},
                   (k == WdT - 1) ? 3'b100 : 3'b010);
            step();
        end
        m0_cyc = 0; m0_stb = 0;
        #1 chk("wd_pulse", {timeout_o, m0_err_o}, 2'b10);
        step();
        #1 chk("wd_pulse_end", timeout_o, 1'b0);

        // Ack on the threshold cycle wins over the watchdog.
        do_reset();
        m0_cyc = 1; m0_stb = 1;
        step();
        for (int k = 0; k < WdT; k++) begin
            s_ack = (k == WdT - 1);
            #1 chk($sformatf("wd_ack%0d", k), {m0_ack_o, m0_err_o, s_stb_o, timeout_o},
                   (k == WdT - 1) ? 4'b1010 : 4'b0010);
            step();
        end
        m0_cyc = 0; m0_stb = 0; s_ack = 0;
        #1 chk("wd_ack_no_pulse", timeout_o, 1'b0);

        // Disabled watchdog holds a 1000-cycle stall.
        do_reset();
        m0_cyc = 1; m0_stb = 1;
        step();
        for (int k = 0; k < 1000; k++) begin
            #1 chk("nowd_stall", {z_grant_o, z_s_stb_o, z_m0_err_o, z_timeout_o}, 5'b01100);
            step();
        end

        // Randomized traffic against the reference model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int r;
            int div;
            div = 5 + 5 * (n / 750);
            if ($urandom_range(0, 9) == 0) m0_cyc = ~m0_cyc;
            if ($urandom_range(0, 9) == 0) m1_cyc = ~m1_cyc;
            m0_stb = m0_cyc & ($urandom_range(0, 4) != 0);
            m1_stb = m1_cyc & ($urandom_range(0, 4) != 0);
            m0_we  = ($urandom_range(0, 1) == 1);
            m1_we  = ($urandom_range(0, 1) == 1);
            m0_adr = $urandom; m1_adr = $urandom;
            r = $urandom_range(0, div);
            s_ack = (r < 2); s_err = (r == 2); s_rty = (r == 3);
            #1 model_expect(e, f, ea);
            chk("rand_outs", dut_vec(), e);
            chk("rand_adr", s_adr_o, ea);
            @(posedge clk);
            model_step(f);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
